// File: rtl/ultrasonic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : ultrasonic_pkg                                             |
// | Brief   : Shared state encoding, default timing constants and small  |
// |           elaboration helpers for the ultrasonic range engine.       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package ultrasonic_pkg;

  localparam int unsigned DEF_CLK_HZ     = 100_000_000;
  localparam int unsigned DEF_TRIG_US    = 10;
  localparam int unsigned DEF_PERIOD_MS  = 60;
  localparam int unsigned DEF_TIMEOUT_US = 25_000;
  localparam int unsigned DEF_US_PER_CM  = 58;
  localparam int unsigned DEF_DIST_W     = 12;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] TRIG      = 3'd1;
  localparam logic [STATE_W-1:0] WAIT_RISE = 3'd2;
  localparam logic [STATE_W-1:0] MEASURE   = 3'd3;
  localparam logic [STATE_W-1:0] HOLDOFF   = 3'd4;

  // Clocks per microsecond; the clock must be an integer number of MHz.
  function automatic int unsigned clks_per_us(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  // Bits needed to hold the values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/us_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : us_tick_gen                                                |
// | Brief   : Microsecond prescaler. One-cycle tick every DIV clocks,    |
// |           realignable with clr so the first tick lands DIV clocks    |
// |           after the clear.                                           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module us_tick_gen
  import ultrasonic_pkg::*;
#(
  parameter int unsigned DIV = clks_per_us(DEF_CLK_HZ)
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divide-by-DIV counter, restarted from zero by clr.
  always_ff @(posedge clk) begin
    if (!reset_p || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/ultrasonic_echo_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ultrasonic_echo_meter                                      |
// | Brief   : HC-SR04 style range engine. Fires periodic triggers,       |
// |           times the echo in microseconds and converts to whole       |
// |           centimetres with a chained us / cm prescaler.              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ultrasonic_echo_meter
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
  parameter int unsigned TRIG_US    = DEF_TRIG_US,
  parameter int unsigned PERIOD_MS  = DEF_PERIOD_MS,
  parameter int unsigned TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int unsigned US_PER_CM  = DEF_US_PER_CM,
  parameter int unsigned DIST_W     = DEF_DIST_W
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              meas_en,
  input  logic              echo_in,
  output logic              trig_out,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              timeout_err,
  output logic              busy
);

  localparam int unsigned CLKS_PER_US = clks_per_us(CLK_HZ);
  localparam int unsigned PERIOD_US   = PERIOD_MS * 1000;
  localparam int unsigned US_MAX      = (TRIG_US > TIMEOUT_US) ? TRIG_US : TIMEOUT_US;
  localparam int unsigned UW          = cnt_width(US_MAX);
  localparam int unsigned PW          = cnt_width(PERIOD_US);
  localparam int unsigned SW          = cnt_width(US_PER_CM - 1);

  localparam logic [UW-1:0]     TRIG_LAST    = UW'(TRIG_US - 1);
  localparam logic [UW-1:0]     TIMEOUT_LAST = UW'(TIMEOUT_US - 1);
  localparam logic [PW-1:0]     PERIOD_END   = PW'(PERIOD_US);
  localparam logic [PW-1:0]     PERIOD_LAST  = PW'(PERIOD_US - 1);
  localparam logic [SW-1:0]     SUB_LAST     = SW'(US_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_MAX       = {DIST_W{1'b1}};

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic               echo_s1, echo_s2, echo_s3;
  logic               echo_rise, echo_fall;
  logic               us_tick, tick_clr;
  logic [UW-1:0]      us_cnt;
  logic [PW-1:0]      period_cnt;
  logic [SW-1:0]      sub_cnt, sub_nxt;
  logic [DIST_W-1:0]  cm_cnt, cm_nxt;
  logic               trig_done, us_timeout, period_done;
  logic               meas_done, cycle_timeout;

  // Microsecond tick, realigned to the trigger rise so every period is exact.
  us_tick_gen #(
    .DIV (CLKS_PER_US)
  ) u_us_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .clr     (tick_clr),
    .tick    (us_tick)
  );

  // Two-flop synchroniser for the asynchronous echo pin plus a history flop.
  always_ff @(posedge clk) begin
    if (!reset_p) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_s3 <= 1'b0;
    end else begin
      echo_s1 <= echo_in;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  assign echo_rise   = echo_s2 & ~echo_s3;
  assign echo_fall   = ~echo_s2 & echo_s3;
  assign trig_done   = us_tick && (us_cnt == TRIG_LAST);
  assign us_timeout  = us_tick && (us_cnt == TIMEOUT_LAST);
  // The period expires on the tick that completes it, so the next trigger
  // lands exactly PERIOD_US microseconds after the previous rise.
  assign period_done = (period_cnt == PERIOD_END) || (us_tick && (period_cnt == PERIOD_LAST));
  assign tick_clr    = (next_state == TRIG) && (state != TRIG);
  // A fall beats a coincident timeout in MEASURE.
  assign meas_done     = (state == MEASURE) && echo_fall;
  assign cycle_timeout = ((state == WAIT_RISE) && !echo_rise && us_timeout) ||
                         ((state == MEASURE) && !echo_fall && us_timeout);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_p) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (meas_en) next_state = TRIG;
      TRIG:      if (trig_done) next_state = WAIT_RISE;
      WAIT_RISE: begin
        if (echo_rise)       next_state = MEASURE;
        else if (us_timeout) next_state = HOLDOFF;
      end
      MEASURE:   if (echo_fall || us_timeout) next_state = HOLDOFF;
      HOLDOFF:   if (period_done) next_state = meas_en ? TRIG : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    trig_out = (state == TRIG);
    busy     = (state != IDLE);
  end

  // Chained prescaler: US_PER_CM ticks make one centimetre, saturating.
  always_comb begin
    sub_nxt = sub_cnt;
    cm_nxt  = cm_cnt;
    if (us_tick) begin
      if (sub_cnt == SUB_LAST) begin
        sub_nxt = '0;
        if (cm_cnt != CM_MAX) cm_nxt = cm_cnt + DIST_W'(1);
      end else begin
        sub_nxt = sub_cnt + SW'(1);
      end
    end
  end

  // Per-state us counter, period counter, range counters and result strobes.
  always_ff @(posedge clk) begin
    if (!reset_p) begin
      us_cnt      <= '0;
      period_cnt  <= '0;
      sub_cnt     <= '0;
      cm_cnt      <= '0;
      dist_cm     <= '0;
      dist_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      dist_valid  <= 1'b0;
      timeout_err <= 1'b0;

      if (next_state != state) us_cnt <= '0;
      else if (us_tick)        us_cnt <= us_cnt + UW'(1);

      if (tick_clr)                                period_cnt <= '0;
      else if (us_tick && period_cnt != PERIOD_END) period_cnt <= period_cnt + PW'(1);

      if (state == WAIT_RISE && next_state == MEASURE) begin
        sub_cnt <= '0;
        cm_cnt  <= '0;
      end else if (state == MEASURE) begin
        sub_cnt <= sub_nxt;
        cm_cnt  <= cm_nxt;
      end

      // Capture includes this cycle's tick so no microsecond is lost.
      if (meas_done) begin
        dist_cm    <= cm_nxt;
        dist_valid <= 1'b1;
      end
      if (cycle_timeout) timeout_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_echo_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ultrasonic_echo_meter                                   |
// | Brief   : Directed self-checking bench for ultrasonic_echo_meter,    |
// |           run with a 4 MHz clock, 1 ms period, 300 us timeout and    |
// |           10 us per cm so a full sequence stays short.               |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_ultrasonic_echo_meter;

  localparam int unsigned N          = 4;      // clocks per us
  localparam int unsigned TRIG_US    = 10;
  localparam int unsigned PERIOD_US  = 1000;
  localparam int unsigned TIMEOUT_US = 300;

  logic        clk = 1'b0;
  logic        reset_p, meas_en, echo_in;
  logic        trig_out, dist_valid, timeout_err, busy;
  logic [11:0] dist_cm;

  int checks = 0, failures = 0;
  int cyc = 0, last_rise = 0;
  int vcount = 0, tcount = 0, both_cnt = 0, trise_cnt = 0;
  int snap;
  logic trig_q = 1'b0;

  ultrasonic_echo_meter #(
    .CLK_HZ     (4_000_000),
    .TRIG_US    (TRIG_US),
    .PERIOD_MS  (1),
    .TIMEOUT_US (TIMEOUT_US),
    .US_PER_CM  (10),
    .DIST_W     (12)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .meas_en     (meas_en),
    .echo_in     (echo_in),
    .trig_out    (trig_out),
    .dist_cm     (dist_cm),
    .dist_valid  (dist_valid),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event tallies sampled mid-cycle.
  always @(negedge clk) begin
    trig_q <= trig_out;
    if (trig_out === 1'b1 && trig_q !== 1'b1) trise_cnt <= trise_cnt + 1;
    if (dist_valid === 1'b1) vcount <= vcount + 1;
    if (timeout_err === 1'b1) tcount <= tcount + 1;
    if (dist_valid === 1'b1 && timeout_err === 1'b1) both_cnt <= both_cnt + 1;
  end

  initial begin
    #700_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for a trigger, optionally check its spacing, then check its width.
  task automatic wait_trig_rise(input bit check_gap);
    int n;
    int hi;
    n = 0;
    while (trig_out !== 1'b1 && n < 2 * PERIOD_US * N) begin
      tick_n(1);
      n++;
    end
    check("trig_seen", 32'(trig_out === 1'b1), 32'd1);
    if (check_gap) check("trig_period", 32'(cyc - last_rise), PERIOD_US * N);
    last_rise = cyc;
    hi = 0;
    while (trig_out === 1'b1 && hi < 4 * TRIG_US * N) begin
      tick_n(1);
      hi++;
    end
    check("trig_width", 32'(hi), TRIG_US * N);
  endtask

  // Drive one echo pulse and check the resulting strobe and distance.
  task automatic echo_pulse(input int delay_us, input int high_us, input int exp_cm);
    tick_n(delay_us * N);
    echo_in = 1'b1;
    tick_n(high_us * N);
    echo_in = 1'b0;
    tick_n(2);
    check("valid_early", 32'(dist_valid), 32'd0);
    tick_n(1);
    check("valid_strobe", 32'(dist_valid), 32'd1);
    check("dist_cm", 32'(dist_cm), 32'(exp_cm));
    tick_n(1);
    check("valid_single", 32'(dist_valid), 32'd0);
  endtask

  // Count clocks from trigger fall to the timeout strobe.
  task automatic wait_timeout(input string tag);
    int n;
    n = 0;
    while (timeout_err !== 1'b1 && n < 2000) begin
      tick_n(1);
      n++;
    end
    check(tag, 32'(n), TIMEOUT_US * N);
  endtask

  initial begin
    reset_p = 1'b0;
    meas_en = 1'b0;
    echo_in = 1'b0;
    tick_n(4);
    check("rst_trig", 32'(trig_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dist", 32'(dist_cm), 32'd0);
    check("rst_valid", 32'(dist_valid), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    reset_p = 1'b1;
    tick_n(3);
    check("idle_busy", 32'(busy), 32'd0);
    meas_en = 1'b1;

    // 100 us echo -> 10 cm
    wait_trig_rise(1'b0);
    echo_pulse(50, 100, 10);

    // 9, 20, 295 us -> 0, 2, 29 cm
    wait_trig_rise(1'b1);
    echo_pulse(20, 9, 0);
    wait_trig_rise(1'b1);
    echo_pulse(20, 20, 2);
    wait_trig_rise(1'b1);
    echo_pulse(2, 295, 29);

    // No echo: timeout, distance retained
    wait_trig_rise(1'b1);
    wait_timeout("timeout_noecho");
    check("dist_kept", 32'(dist_cm), 32'd29);
    echo_in = 1'b1;

    // Echo stuck high before trigger: timeout only
    wait_trig_rise(1'b1);
    wait_timeout("timeout_stuck");
    tick_n(1);
    check("valid_count_stuck", 32'(vcount), 32'd4);
    check("timeout_count", 32'(tcount), 32'd2);
    echo_in = 1'b0;

    // Reset in the middle of MEASURE
    wait_trig_rise(1'b1);
    tick_n(40);
    echo_in = 1'b1;
    tick_n(200);
    reset_p = 1'b0;
    echo_in = 1'b0;
    tick_n(1);
    check("abort_trig", 32'(trig_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dist", 32'(dist_cm), 32'd0);
    check("abort_valid", 32'(dist_valid), 32'd0);
    check("abort_timeout", 32'(timeout_err), 32'd0);
    reset_p = 1'b1;
    tick_n(1);
    check("restart_trig", 32'(trig_out), 32'd1);

    // meas_en dropped during WAIT_RISE: cycle completes, then IDLE
    wait_trig_rise(1'b0);
    meas_en = 1'b0;
    check("busy_wait", 32'(busy), 32'd1);
    snap = trise_cnt;
    echo_pulse(50, 100, 10);
    tick_n(4500);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_trig", 32'(trig_out), 32'd0);
    check("no_retrigger", 32'(trise_cnt), 32'(snap));
    check("valid_total", 32'(vcount), 32'd5);
    check("timeout_total", 32'(tcount), 32'd2);
    check("strobe_overlap", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
